// File: rtl/count_monitor.sv
// Watches a sampled 4-bit up/down counter and classifies each step as hold/up/down/jump,
// keeping a run length of identical classes and saturating per-class event totals.
module count_monitor #(
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             claer,
  input  logic             sample,
  input  logic [3:0]       count_in,
  output logic [1:0]       op,
  output logic             op_valid,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic [3:0]       run_len,
  output logic [EVT_W-1:0] up_cnt,
  output logic [EVT_W-1:0] down_cnt,
  output logic [EVT_W-1:0] jump_cnt,
  output logic             armed
);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  state_t           state_reg, state_next;
  logic [3:0]       prev_reg, prev_next;
  logic             first_reg, first_next;
  logic [1:0]       op_reg, op_next;
  logic             op_valid_reg, op_valid_next;
  logic             wrap_up_reg, wrap_up_next;
  logic             wrap_down_reg, wrap_down_next;
  logic [3:0]       run_len_reg, run_len_next;
  logic [EVT_W-1:0] up_cnt_reg, up_cnt_next;
  logic [EVT_W-1:0] down_cnt_reg, down_cnt_next;
  logic [EVT_W-1:0] jump_cnt_reg, jump_cnt_next;

  logic [3:0] step;
  logic [1:0] cls;

  // Modulo-16 difference: +1 is up, -1 (15) is down, including across the wrap.
  assign step = count_in - prev_reg;

  always_comb begin
    unique case (step)
      4'd0:    cls = OP_HOLD;
      4'd1:    cls = OP_UP;
      4'd15:   cls = OP_DOWN;
      default: cls = OP_JUMP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (claer) begin
      state_reg     <= IDLE;
      prev_reg      <= '0;
      first_reg     <= 1'b0;
      op_reg        <= OP_HOLD;
      op_valid_reg  <= 1'b0;
      wrap_up_reg   <= 1'b0;
      wrap_down_reg <= 1'b0;
      run_len_reg   <= '0;
      up_cnt_reg    <= '0;
      down_cnt_reg  <= '0;
      jump_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      first_reg     <= first_next;
      op_reg        <= op_next;
      op_valid_reg  <= op_valid_next;
      wrap_up_reg   <= wrap_up_next;
      wrap_down_reg <= wrap_down_next;
      run_len_reg   <= run_len_next;
      up_cnt_reg    <= up_cnt_next;
      down_cnt_reg  <= down_cnt_next;
      jump_cnt_reg  <= jump_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    first_next     = first_reg;
    op_next        = op_reg;
    op_valid_next  = 1'b0;
    wrap_up_next   = 1'b0;
    wrap_down_next = 1'b0;
    run_len_next   = run_len_reg;
    up_cnt_next    = up_cnt_reg;
    down_cnt_next  = down_cnt_reg;
    jump_cnt_next  = jump_cnt_reg;

    if (sample) begin
      unique case (state_reg)
        IDLE: begin
          prev_next  = count_in;
          state_next = TRACK;
          first_next = 1'b1;
        end
        TRACK: begin
          prev_next      = count_in;
          first_next     = 1'b0;
          op_next        = cls;
          op_valid_next  = 1'b1;
          wrap_up_next   = (cls == OP_UP)   && (prev_reg == 4'd15);
          wrap_down_next = (cls == OP_DOWN) && (prev_reg == 4'd0);
          // A new run starts on the first class after arming or on a class change.
          if (first_reg || (cls != op_reg)) begin
            run_len_next = 4'd1;
          end else if (run_len_reg != 4'd15) begin
            run_len_next = run_len_reg + 4'd1;
          end
          if ((cls == OP_UP) && (up_cnt_reg != '1)) begin
            up_cnt_next = up_cnt_reg + 1'b1;
          end
          if ((cls == OP_DOWN) && (down_cnt_reg != '1)) begin
            down_cnt_next = down_cnt_reg + 1'b1;
          end
          if ((cls == OP_JUMP) && (jump_cnt_reg != '1)) begin
            jump_cnt_next = jump_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign op        = op_reg;
  assign op_valid  = op_valid_reg;
  assign wrap_up   = wrap_up_reg;
  assign wrap_down = wrap_down_reg;
  assign run_len   = run_len_reg;
  assign up_cnt    = up_cnt_reg;
  assign down_cnt  = down_cnt_reg;
  assign jump_cnt  = jump_cnt_reg;
  assign armed     = (state_reg == TRACK);

endmodule
